// File: rtl/deparser_do_deparsing.sv
// rtl/deparser_do_deparsing.sv - packet deparser: writes PHV containers back into the packet's first segments
module deparser_do_deparsing #(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int PKT_HDR_LEN        = 1024,
   parameter int C_NUM_SEGS         = 2,
   parameter int C_PARSER_RAM_WIDTH = 160,
   parameter int C_VLANID_WIDTH     = 12
)(
   input  logic                                   clk,
   input  logic                                   aresetn,
   input  logic [PKT_HDR_LEN-1:0]                 phv_in,
   input  logic                                   phv_in_valid,
   input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in,
   input  logic                                   segs_in_valid,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]          tuser_1st_in,
   output logic                                   in_ready,
   output logic [C_VLANID_WIDTH-1:0]              bram_addr,
   input  logic [C_PARSER_RAM_WIDTH-1:0]          bram_in,
   output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_out,
   output logic [C_AXIS_TUSER_WIDTH-1:0]          tuser_1st_out,
   output logic                                   segs_out_valid,
   input  logic                                   segs_out_ready
);

   localparam int SEGS_W      = C_NUM_SEGS*C_AXIS_DATA_WIDTH;
   localparam int NUM_BYTES   = SEGS_W/8;
   localparam int NUM_ACTIONS = C_PARSER_RAM_WIDTH/16;
   localparam logic [3:0] LAST_ACT = 4'(NUM_ACTIONS-1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] DEPARSE = 2'd2;
   localparam logic [1:0] OUTPUT  = 2'd3;

   logic [1:0]                    state;
   logic [PKT_HDR_LEN-1:256]      phv_r;
   logic [SEGS_W-1:0]             segs_r;
   logic [SEGS_W-1:0]             segs_nxt;
   logic [C_AXIS_TUSER_WIDTH-1:0] tuser_r;
   logic [C_PARSER_RAM_WIDTH-1:0] actions_r;
   logic [3:0]                    cnt;

   logic [15:0] act;
   logic [1:0]  act_type;
   logic [2:0]  act_idx;
   logic [6:0]  act_off;
   logic [47:0] cval;
   int          act_len;
   int          byte_idx;

   // metadata bits outside the VLAN id and the reserved action bits carry nothing for this stage
   logic unused_bits;
   assign unused_bits = ^{phv_in[127:0], phv_in[255:128+C_VLANID_WIDTH], act[2:0]};

   assign in_ready       = aresetn && (state == IDLE) && phv_in_valid && segs_in_valid;
   assign segs_out_valid = (state == OUTPUT);
   assign segs_out       = segs_r;
   assign tuser_1st_out  = tuser_r;

   // container value is left-aligned in cval so byte j is always cval[47-8j -: 8]
   always_comb begin
      act      = actions_r[{cnt, 4'b0000} +: 16];
      act_type = act[14:13];
      act_idx  = act[12:10];
      act_off  = act[9:3];
      cval     = '0;
      act_len  = 0;
      byte_idx = 0;
      case (act_type)
         2'b01: begin
            cval    = {phv_r[256 + 16*int'(act_idx) +: 16], 32'b0};
            act_len = 2;
         end
         2'b10: begin
            cval    = {phv_r[384 + 32*int'(act_idx) +: 32], 16'b0};
            act_len = 4;
         end
         2'b11: begin
            cval    = phv_r[640 + 48*int'(act_idx) +: 48];
            act_len = 6;
         end
         default: begin
            cval    = '0;
            act_len = 0;
         end
      endcase
      segs_nxt = segs_r;
      if (act[15]) begin
         for (int j = 0; j < 6; j++) begin
            byte_idx = int'(act_off) + j;
            if (j < act_len && byte_idx < NUM_BYTES)
               segs_nxt[8*byte_idx +: 8] = cval[47-8*j -: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         phv_r     <= '0;
         segs_r    <= '0;
         tuser_r   <= '0;
         actions_r <= '0;
         cnt       <= '0;
         bram_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_ready) begin
                  phv_r     <= phv_in[PKT_HDR_LEN-1:256];
                  segs_r    <= segs_in;
                  tuser_r   <= tuser_1st_in;
                  bram_addr <= phv_in[128 +: C_VLANID_WIDTH];
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               actions_r <= bram_in;
               cnt       <= '0;
               state     <= DEPARSE;
            end
            DEPARSE: begin
               segs_r <= segs_nxt;
               if (cnt == LAST_ACT) begin
                  cnt   <= '0;
                  state <= OUTPUT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            OUTPUT: begin
               if (segs_out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deparser_do_deparsing.sv
// tb/tb_deparser_do_deparsing.sv - randomized self-checking bench for deparser_do_deparsing
module tb_deparser_do_deparsing;

   logic           clk = 1'b0;
   logic           aresetn;
   logic [1023:0]  phv_in;
   logic           phv_in_valid;
   logic [1023:0]  segs_in;
   logic           segs_in_valid;
   logic [127:0]   tuser_1st_in;
   logic           in_ready;
   logic [11:0]    bram_addr;
   logic [159:0]   bram_in;
   logic [1023:0]  segs_out;
   logic [127:0]   tuser_1st_out;
   logic           segs_out_valid;
   logic           segs_out_ready;

   logic [159:0]   ram_mem [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign bram_in = ram_mem[bram_addr];

   deparser_do_deparsing dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .phv_in         (phv_in),
      .phv_in_valid   (phv_in_valid),
      .segs_in        (segs_in),
      .segs_in_valid  (segs_in_valid),
      .tuser_1st_in   (tuser_1st_in),
      .in_ready       (in_ready),
      .bram_addr      (bram_addr),
      .bram_in        (bram_in),
      .segs_out       (segs_out),
      .tuser_1st_out  (tuser_1st_out),
      .segs_out_valid (segs_out_valid),
      .segs_out_ready (segs_out_ready)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_segs(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s[%0d]", tag, i), got[128*i +: 128], exp[128*i +: 128]);
   endtask

   function automatic logic [15:0] mk_act(input int ty, input int ci, input int off);
      return 16'((1 << 15) | (ty << 13) | (ci << 10) | (off << 3));
   endfunction

   // byte-array reference: walk actions in order, later writes win, drop bytes past 127
   function automatic logic [1023:0] model(input logic [1023:0] phv, input logic [1023:0] segs,
                                           input logic [159:0] ent);
      logic [7:0]      b [128];
      logic [1023:0]   r;
      logic [15:0]     a;
      int              ty, ci, off, nb, base;
      longint unsigned v;
      for (int i = 0; i < 128; i++) b[i] = segs[8*i +: 8];
      for (int k = 0; k < 10; k++) begin
         a   = ent[16*k +: 16];
         ty  = int'(a[14:13]);
         ci  = int'(a[12:10]);
         off = int'(a[9:3]);
         if (a[15] && ty != 0) begin
            nb   = 2 * ty;
            base = (ty == 1) ? 256 + 16*ci : (ty == 2) ? 384 + 32*ci : 640 + 48*ci;
            v    = 64'(phv >> base) & ((64'd1 << (8*nb)) - 64'd1);
            for (int j = 0; j < nb; j++)
               if (off + j < 128) b[off + j] = 8'(v >> (8*(nb - 1 - j)));
         end
      end
      for (int i = 0; i < 128; i++) r[8*i +: 8] = b[i];
      return r;
   endfunction

   // entered just after a posedge; leaves just after the handshake posedge
   task automatic run_pkt(input string nm, input logic [1023:0] p, input logic [1023:0] s,
                          input logic [127:0] tu, input logic [159:0] ent, input int stall,
                          input logic [1023:0] exp_segs);
      int            lat;
      logic [1023:0] held;
      logic [11:0]   vl;
      vl = p[128 +: 12];
      ram_mem[vl]   = ent;
      phv_in        = p;
      segs_in       = s;
      tuser_1st_in  = tu;
      phv_in_valid  = 1'b1;
      segs_in_valid = 1'b1;
      @(negedge clk);
      check({nm, "_in_ready"}, 128'(in_ready), 128'(1));
      check({nm, "_idle_valid"}, 128'(segs_out_valid), 128'(0));
      @(posedge clk); #1;
      phv_in_valid  = 1'b0;
      segs_in_valid = 1'b0;
      @(negedge clk);
      check({nm, "_bram_addr"}, 128'(bram_addr), 128'(vl));
      lat = 1;
      while (!segs_out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 128'(lat), 128'(12));
      check_segs({nm, "_segs"}, segs_out, exp_segs);
      check({nm, "_tuser"}, tuser_1st_out, tu);
      held          = segs_out;
      phv_in_valid  = 1'b1;
      segs_in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({nm, "_stall_valid"}, 128'(segs_out_valid), 128'(1));
         check({nm, "_stall_stable"}, 128'(segs_out == held), 128'(1));
         check({nm, "_stall_in_ready"}, 128'(in_ready), 128'(0));
      end
      phv_in_valid   = 1'b0;
      segs_in_valid  = 1'b0;
      segs_out_ready = 1'b1;
      @(posedge clk); #1;
      segs_out_ready = 1'b0;
   endtask

   function automatic logic [1023:0] rand_vec();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      logic [1023:0] p, s, e;
      logic [159:0]  ent;
      int            n;

      for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
      aresetn        = 1'b0;
      phv_in         = '0;
      segs_in        = '0;
      tuser_1st_in   = '0;
      phv_in_valid   = 1'b1;
      segs_in_valid  = 1'b1;
      segs_out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_valid", 128'(segs_out_valid), 128'(0));
      check("rst_bram_addr", 128'(bram_addr), 128'(0));
      check("rst_tuser", tuser_1st_out, 128'(0));
      check_segs("rst_segs", segs_out, '0);
      phv_in_valid  = 1'b0;
      segs_in_valid = 1'b0;
      @(posedge clk); #1;
      aresetn = 1'b1;
      @(posedge clk); #1;

      // basic 2B write
      p = '0;
      p[128 +: 12] = 12'd5;
      p[256 + 48 +: 16] = 16'hABCD;
      ent = '0;
      ent[15:0] = 16'hAC60;
      e = '0;
      e[8*12 +: 8] = 8'hAB;
      e[8*13 +: 8] = 8'hCD;
      run_pkt("basic", p, '0, 128'h1234, ent, 0, e);

      // handshake: segments alone are not enough
      segs_in       = rand_vec();
      segs_in_valid = 1'b1;
      phv_in_valid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("segs_only_in_ready", 128'(in_ready), 128'(0));
      end
      @(posedge clk); #1;

      // overlap ordering, with a 5-cycle output stall
      p = rand_vec();
      p[128 +: 12] = 12'd9;
      p[384 + 64 +: 32] = 32'hDEADBEEF;
      p[256 + 16 +: 16] = 16'h1234;
      s = rand_vec();
      ent = '0;
      ent[15:0]  = mk_act(2, 2, 20);
      ent[31:16] = mk_act(1, 1, 21);
      e = s;
      e[8*20 +: 8] = 8'hDE;
      e[8*21 +: 8] = 8'h12;
      e[8*22 +: 8] = 8'h34;
      e[8*23 +: 8] = 8'hEF;
      run_pkt("overlap", p, s, {$urandom, $urandom, $urandom, $urandom}, ent, 5, e);

      // boundary truncation, accepted in the cycle right after the handshake
      p = rand_vec();
      p[128 +: 12] = 12'd7;
      p[640 +: 48] = 48'h112233445566;
      s = rand_vec();
      ent = '0;
      ent[15:0] = mk_act(3, 0, 125);
      e = s;
      e[8*125 +: 8] = 8'h11;
      e[8*126 +: 8] = 8'h22;
      e[8*127 +: 8] = 8'h33;
      run_pkt("trunc", p, s, 128'hFEED, ent, 1, e);

      // reset in the middle of DEPARSE
      p = rand_vec();
      ent = '0;
      ent[15:0] = mk_act(3, 1, 0);
      ram_mem[p[128 +: 12]] = ent;
      phv_in        = p;
      segs_in       = rand_vec();
      phv_in_valid  = 1'b1;
      segs_in_valid = 1'b1;
      @(posedge clk); #1;
      phv_in_valid  = 1'b0;
      segs_in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      aresetn = 1'b0;
      #1;
      check("midrst_valid", 128'(segs_out_valid), 128'(0));
      phv_in_valid  = 1'b1;
      segs_in_valid = 1'b1;
      #1;
      check("midrst_in_ready", 128'(in_ready), 128'(0));
      phv_in_valid  = 1'b0;
      segs_in_valid = 1'b0;
      @(negedge clk);
      check_segs("midrst_segs", segs_out, '0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (segs_out_valid) n++;
      end
      check("midrst_no_output", 128'(n), 128'(0));
      @(posedge clk); #1;

      p = '0;
      p[128 +: 12] = 12'd5;
      p[256 + 48 +: 16] = 16'hABCD;
      ent = '0;
      ent[15:0] = 16'hAC60;
      e = '0;
      e[8*12 +: 8] = 8'hAB;
      e[8*13 +: 8] = 8'hCD;
      run_pkt("after_rst", p, '0, 128'h55, ent, 0, e);

      // randomized packets against the reference model
      for (int t = 0; t < 10; t++) begin
         p = rand_vec();
         s = rand_vec();
         for (int k = 0; k < 10; k++) begin
            ent[16*k +: 16] = 16'($urandom);
            ent[16*k + 15]  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
               ent[16*k + 3 +: 7] = 7'($urandom_range(120, 127));
         end
         e = model(p, s, ent);
         run_pkt($sformatf("rnd%0d", t), p, s, {$urandom, $urandom, $urandom, $urandom},
                 ent, $urandom_range(0, 3), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
